// File: rtl/minhour_cnt_if.sv
// Signal bundle between the minute/hour stage and its neighbours: seconds
// carry, blink tick and buttons in; BCD digits, set-mode status and day carry out.
interface minhour_cnt_if;
  logic       EN;
  logic       TICK;
  logic       MODE_BTN;
  logic       UP_BTN;
  logic [2:0] MH;
  logic [3:0] ML;
  logic [1:0] HH;
  logic [3:0] HL;
  logic       SEC_CLR;
  logic [1:0] SETMODE;
  logic       HVIS;
  logic       MVIS;
  logic       CA;

  // Upstream / stimulus side: drives carry, tick and buttons.
  modport master (
    output EN, TICK, MODE_BTN, UP_BTN,
    input  MH, ML, HH, HL, SEC_CLR, SETMODE, HVIS, MVIS, CA
  );

  // Counter side.
  modport slave (
    input  EN, TICK, MODE_BTN, UP_BTN,
    output MH, ML, HH, HL, SEC_CLR, SETMODE, HVIS, MVIS, CA
  );
endinterface

// File: rtl/minhour_cnt.sv
// Minute/hour stage of the 24-hour clock: BCD minutes and hours driven by the
// seconds carry, plus the time-set UI (MODE/UP buttons, UP auto-repeat,
// digit blink and a clear strobe back to the seconds counter).
module minhour_cnt #(
  parameter logic [15:0] RPT_DELAY  = 16'd500,
  parameter logic [15:0] RPT_PERIOD = 16'd100
) (
  input logic         CLK,
  input logic         RST,
  minhour_cnt_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } state_t;

  state_t      state, state_nxt;
  logic        sec_clr;
  logic        blink;
  logic [6:0]  mins;      // {tens, units}
  logic [5:0]  hrs;       // {tens, units}
  logic        mode_prev, up_prev;
  logic [15:0] hold_cnt, hold_inc;
  logic        mode_evt, up_rise, rpt_evt, up_evt;

  // Minutes +1 in BCD, 59 wraps to 00.
  function automatic logic [6:0] min_inc(input logic [6:0] m);
    if (m[3:0] == 4'd9) begin
      if (m[6:4] == 3'd5) return 7'h00;
      return {m[6:4] + 3'd1, 4'd0};
    end
    return {m[6:4], m[3:0] + 4'd1};
  endfunction

  // Hours +1 in BCD, 23 wraps to 00.
  function automatic logic [5:0] hour_inc(input logic [5:0] h);
    if (h == 6'h23) return 6'h00;
    if (h[3:0] == 4'd9) return {h[5:4] + 2'd1, 4'd0};
    return {h[5:4], h[3:0] + 4'd1};
  endfunction

  assign mode_evt = bus.MODE_BTN & ~mode_prev;
  assign up_rise  = bus.UP_BTN & ~up_prev;
  assign hold_inc = (hold_cnt == 16'hFFFF) ? hold_cnt : hold_cnt + 16'd1;
  assign rpt_evt  = bus.UP_BTN & ~up_rise & (hold_inc == RPT_DELAY);
  assign up_evt   = up_rise | rpt_evt;

  // Button edge history and UP hold counter for auto-repeat.
  always_ff @(posedge CLK) begin
    // NOTE: reset is sampled on the clock edge, and every register here is
    // assigned non-blocking so all state updates see pre-edge values.
    if (!RST) begin
      mode_prev <= 1'b1;
      up_prev   <= 1'b1;
      hold_cnt  <= 16'd0;
    end else begin
      mode_prev <= bus.MODE_BTN;
      up_prev   <= bus.UP_BTN;
      if (!bus.UP_BTN || up_rise) hold_cnt <= 16'd0;
      else if (rpt_evt)           hold_cnt <= RPT_DELAY - RPT_PERIOD;
      else                        hold_cnt <= hold_inc;
    end
  end

  // Next set-mode state: MODE steps RUN -> SET_HOUR -> SET_MIN -> RUN.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    if (mode_evt) begin
      unique case (state)
        RUN:      state_nxt = SET_HOUR;
        SET_HOUR: state_nxt = SET_MIN;
        default:  state_nxt = RUN;
      endcase
    end
  end

  // Set-mode FSM with registered status, blink and the time digits.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= RUN;
      sec_clr <= 1'b0;
      blink   <= 1'b1;
      mins    <= 7'h00;
      hrs     <= 6'h00;
    end else begin
      state   <= state_nxt;
      sec_clr <= (state_nxt != RUN);

      // Digits stay lit in RUN, on any mode change and right after an edit.
      if (state == RUN || state_nxt != state || up_evt) blink <= 1'b1;
      else if (bus.TICK)                                 blink <= ~blink;

      // A MODE event in the same cycle swallows the UP event.
      unique case (state)
        RUN: begin
          if (bus.EN) begin
            mins <= min_inc(mins);
            if (mins == 7'h59) hrs <= hour_inc(hrs);
          end
        end
        SET_HOUR: if (up_evt && !mode_evt) hrs  <= hour_inc(hrs);
        SET_MIN:  if (up_evt && !mode_evt) mins <= min_inc(mins);
        default: ;
      endcase
    end
  end

  assign bus.MH      = mins[6:4];
  assign bus.ML      = mins[3:0];
  assign bus.HH      = hrs[5:4];
  assign bus.HL      = hrs[3:0];
  assign bus.SEC_CLR = sec_clr;
  assign bus.SETMODE = state;
  assign bus.HVIS    = ~((state == SET_HOUR) & ~blink);
  assign bus.MVIS    = ~((state == SET_MIN) & ~blink);
  assign bus.CA      = (state == RUN) & bus.EN & (hrs == 6'h23) & (mins == 7'h59);

endmodule

// File: tb/tb_minhour_cnt.sv
// Self-checking bench for minhour_cnt: directed time-set scenarios followed by
// random stimulus, all compared every cycle against a behavioural model that
// keeps the time as plain integers.
module tb_minhour_cnt;
  localparam int D = 500;
  localparam int P = 100;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  minhour_cnt_if bus ();

  minhour_cnt #(.RPT_DELAY(16'(D)), .RPT_PERIOD(16'(P))) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: time as integers, mode 0/1/2, cycles UP held since its rise.
  int m_min = 0, m_hr = 0, m_mode = 0, m_held = 0;
  bit m_blink = 1, m_mprev = 1, m_uprev = 1, m_valid = 0;

  function automatic logic [17:0] exp_outs();
    bit hvis, mvis;
    hvis = !(m_mode == 1 && !m_blink);
    mvis = !(m_mode == 2 && !m_blink);
    return {3'(m_min / 10), 4'(m_min % 10), 2'(m_hr / 10), 4'(m_hr % 10),
            m_mode != 0, 2'(m_mode), hvis, mvis};
  endfunction

  // One clock cycle: drive inputs, check CA before the edge, advance the
  // model at the edge, check registered outputs just after it.
  task automatic step(input bit rst, input bit en, input bit tick, input bit mode, input bit up);
    bit mode_evt, up_rise, rpt, up_evt;
    int old_mode;
    RST = rst; bus.EN = en; bus.TICK = tick; bus.MODE_BTN = mode; bus.UP_BTN = up;
    #1;
    if (m_valid) check("ca", bus.CA, 32'(m_mode == 0 && en && m_hr == 23 && m_min == 59));
    @(posedge CLK);
    if (!rst) begin
      m_min = 0; m_hr = 0; m_mode = 0; m_held = 0;
      m_blink = 1; m_mprev = 1; m_uprev = 1; m_valid = 1;
    end else begin
      mode_evt = mode && !m_mprev;
      up_rise  = up && !m_uprev;
      if (!up || up_rise) m_held = 0;
      else m_held++;
      rpt    = up && !up_rise && m_held >= D && ((m_held - D) % P) == 0;
      up_evt = up_rise || rpt;
      old_mode = m_mode;
      if (m_mode == 0 && en) begin
        m_min++;
        if (m_min == 60) begin m_min = 0; m_hr = (m_hr + 1) % 24; end
      end else if (m_mode == 1 && up_evt && !mode_evt) m_hr = (m_hr + 1) % 24;
      else if (m_mode == 2 && up_evt && !mode_evt) m_min = (m_min + 1) % 60;
      if (mode_evt) m_mode = (m_mode + 1) % 3;
      if (m_mode != old_mode || old_mode == 0 || up_evt) m_blink = 1;
      else if (tick) m_blink = !m_blink;
      m_mprev = mode; m_uprev = up;
    end
    #1;
    check("outs", {bus.MH, bus.ML, bus.HH, bus.HL, bus.SEC_CLR, bus.SETMODE, bus.HVIS, bus.MVIS},
          exp_outs());
  endtask

  task automatic press_mode();
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
  endtask

  task automatic press_up(input int n);
    repeat (n) begin
      step(1, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m);
    check(tag, {bus.HH, bus.HL, bus.MH, bus.ML},
          {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)});
  endtask

  initial begin
    bit mode_lvl, up_lvl;
    mode_lvl = 0; up_lvl = 0;

    // Reset with both buttons held: no mode change once reset releases.
    repeat (3) step(0, 0, 0, 1, 1);
    repeat (3) step(1, 0, 0, 1, 1);
    check_time("rst_time", 0, 0);
    check("rst_setmode", bus.SETMODE, 0);
    check("rst_secclr", bus.SEC_CLR, 0);
    check("rst_vis", {bus.HVIS, bus.MVIS}, 2'b11);
    step(1, 0, 0, 0, 0);

    // Set 12:59, then one seconds carry -> 13:00.
    press_mode(); press_up(12);
    press_mode(); press_up(59);
    press_mode();
    check_time("set_1259", 12, 59);
    step(1, 1, 0, 0, 0);
    check_time("carry_1300", 13, 0);

    // Set 23:59, carry produces CA then 00:00.
    press_mode(); press_up(10);
    press_mode(); press_up(59);
    press_mode();
    RST = 1; bus.EN = 1;
    #1;
    check("ca_2359", bus.CA, 1);
    step(1, 1, 0, 0, 0);
    check_time("wrap_0000", 0, 0);

    // SET_HOUR: hours wrap, minutes untouched, EN ignored.
    press_mode();
    check("sethour_mode", {bus.SETMODE, bus.SEC_CLR}, 3'b011);
    press_up(22);
    repeat (5) begin
      step(1, 1, 0, 0, 1);
      step(1, 1, 0, 0, 0);
    end
    check_time("hour_wrap", 3, 0);

    // Blink: three ticks give HVIS 0,1,0; an edit forces it back on.
    step(1, 0, 1, 0, 0); check("blink1", {bus.HVIS, bus.MVIS}, 2'b01);
    step(1, 0, 1, 0, 0); check("blink2", {bus.HVIS, bus.MVIS}, 2'b11);
    step(1, 0, 1, 0, 0); check("blink3", {bus.HVIS, bus.MVIS}, 2'b01);
    step(1, 0, 0, 0, 1); check("blink_up", bus.HVIS, 1);
    step(1, 0, 0, 0, 0);
    press_mode();
    check("setmin_vis", {bus.SETMODE, bus.HVIS}, 3'b101);

    // Auto-repeat from 58: events at rise, cycle 500, cycle 600.
    press_up(58);
    repeat (500) step(1, 0, 0, 0, 1);
    check_time("rpt_rise", 4, 59);
    step(1, 0, 0, 0, 1);
    check_time("rpt_500", 4, 0);
    repeat (100) step(1, 0, 0, 0, 1);
    check_time("rpt_600", 4, 1);
    repeat (99) step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);

    // MODE and UP rise together: mode wins.
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0);
    check("both_mode", bus.SETMODE, 0);
    check_time("both_time", 4, 1);

    // Reset in the middle of an auto-repeat hold.
    press_mode(); press_mode();
    repeat (550) step(1, 0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0, 1);
    check_time("midrpt_rst", 0, 0);
    check("midrpt_mode", bus.SETMODE, 0);
    repeat (20) step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    press_mode(); press_mode();
    check_time("post_rst_min", 0, 0);
    press_up(1);
    check_time("fresh_rise", 0, 1);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bit r_rst, en, tick;
      r_rst = ($urandom_range(999) != 0);
      en    = ($urandom_range(19) == 0);
      tick  = ($urandom_range(9) == 0);
      if ($urandom_range(29) == 0) mode_lvl = !mode_lvl;
      if (up_lvl ? ($urandom_range(399) == 0) : ($urandom_range(19) == 0)) up_lvl = !up_lvl;
      step(r_rst, en, tick, mode_lvl, up_lvl);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/minhour_cnt.md
Name: minhour_cnt

Overview:
- Minute/hour stage of the 24-hour clock, directly downstream of the seconds counter.
- Consumes the seconds carry and keeps BCD minutes (00-59) and hours (00-23).
- Owns the time-set user interface: MODE/UP buttons, a set-mode FSM, UP auto-repeat, digit blink, and a clear strobe back to the seconds counter.
- Outputs feed the display/decoder stage.

Parameters:
RPT_DELAY, 16'd500, CLK cycles UP must be held before the first auto-repeat event
RPT_PERIOD, 16'd100, CLK cycles between subsequent auto-repeat events (must be >=1)

Ports:
CLK      input   1  system clock, all logic on rising edge
RST      input   1  synchronous reset, active-low (0 = reset)
EN       input   1  seconds carry: one-cycle pulse when seconds wrap 59->00
TICK     input   1  1 Hz one-cycle pulse (seconds-counter enable), used for blink timing
MODE_BTN input   1  debounced level, mode-step button
UP_BTN   input   1  debounced level, increment button
MH       output  3  minutes tens, BCD 0-5
ML       output  4  minutes units, BCD 0-9
HH       output  2  hours tens, BCD 0-2
HL       output  4  hours units, BCD 0-9
SEC_CLR  output  1  registered; high while in a set state; drives seconds-counter CLR
SETMODE  output  2  registered state code: 00 RUN, 01 SET_HOUR, 10 SET_MIN
HVIS     output  1  hour digits visible (0 only during blink-off in SET_HOUR)
MVIS     output  1  minute digits visible (0 only during blink-off in SET_MIN)
CA       output  1  day carry, combinational

Behaviour:
- Reset (RST==0 at a clock edge):
  - MH=ML=HH=HL=0; state RUN; SETMODE=00; SEC_CLR=0.
  - Blink register=1, so HVIS=MVIS=1.
  - Hold counter=0.
  - Button previous-sample registers=1, so a button held through reset produces no edge after reset releases.
  - Reset overrides everything, including mid-set and mid-repeat.
- Edge detect: mode_evt = MODE_BTN & ~mode_prev; up_rise = UP_BTN & ~up_prev. Prev registers sample every cycle.
- Auto-repeat:
  - Hold counter clears whenever UP_BTN==0 or on up_rise; otherwise it increments.
  - On reaching RPT_DELAY, a repeat event fires and the counter reloads to RPT_DELAY-RPT_PERIOD.
  - up_evt = up_rise | repeat event.
  - Counter saturates and never wraps.
- FSM, advancing on mode_evt: RUN -> SET_HOUR -> SET_MIN -> RUN.
  - mode_evt and up_evt in the same cycle: mode wins, up_evt discarded.
- RUN:
  - On EN: ML+1. ML 9->0 increments MH. MH:ML 59->00 increments the hour.
  - Hour: HL 9->0 increments HH. HH:HL 23->00 wraps.
  - up_evt ignored.
- SET_HOUR:
  - EN ignored.
  - up_evt increments the hour 23->00; minutes untouched.
- SET_MIN:
  - EN ignored.
  - up_evt increments minutes 59->00; no carry into hours.
- All updates are visible one cycle after the qualifying edge (single register stage).
- SEC_CLR = (state != RUN), registered with the state.
  - On the SET_MIN->RUN edge, SEC_CLR drops in the same cycle SETMODE becomes 00, so seconds restart from 00.
- Blink:
  - Register forced to 1 in RUN, on any state change, and on up_evt.
  - Otherwise toggles on TICK while in a set state.
  - HVIS = ~(SET_HOUR & ~blink); MVIS = ~(SET_MIN & ~blink).
- CA = RUN & EN & HH==2 & HL==3 & MH==5 & ML==9. CA is 0 in set states.
- Digit values outside BCD range are unreachable; no recovery logic is required.

Test Plan:
- Reset with buttons held high -> after release: 00:00, SETMODE=00, SEC_CLR=0, HVIS=MVIS=1; no mode change until MODE_BTN goes 0 then 1.
- RUN at 12:59, one EN pulse -> 13:00 next cycle. At 23:59 with EN -> CA=1 that cycle, then 00:00.
- One MODE rise -> SETMODE=01, SEC_CLR=1. 5 UP rises from 22:xx -> hours 22,23,00,01,02,03; minutes unchanged. EN pulses ignored.
- SET_MIN at 58, UP held 700 cycles (RPT_DELAY=500, RPT_PERIOD=100):
  - Event at rise -> 59.
  - Event at cycle 500 -> 00; hours unchanged.
  - Event at cycle 600 -> 01.
  - Release clears the hold counter.
- In SET_HOUR, 3 TICKs -> HVIS sequence 0,1,0 (MVIS stays 1). An up_evt forces HVIS=1. Next MODE rise -> SET_MIN, HVIS=1.
- Simultaneous MODE and UP rise in SET_MIN -> RUN, minutes unchanged. RST=0 asserted mid auto-repeat -> 00:00 RUN; repeat resumes only after a fresh UP rise.
